// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding, common to the TX and RX sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        UART_IDLE      = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial pin in, received byte plus status strobes out.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      rx;
  logic [UART_DATA_BITS-1:0] data_out;
  logic                      rx_done;
  logic                      frame_err;
  logic                      busy;

  // master = the receiver itself, slave = whatever drives the pin and consumes bytes
  modport master (
    input  rx,
    output data_out,
    output rx_done,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data_out,
    input  rx_done,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input; reset level is configurable.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle byte strobe, framing-error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic      clock,
  input  logic      reset,
  uart_rx_if.master bus
);

  localparam int unsigned         CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]    CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

  generate
    if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT % 2 != 0)) begin : g_bad_param
      $error("uart_rx: CLKS_PER_BIT must be even and at least 4");
    end
  endgenerate

  logic                      rx_s;
  uart_rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      done_q, done_d;
  logic                      ferr_q, ferr_d;

  uart_sync #(
    .RESET_VAL(UART_IDLE)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (bus.rx),
    .q    (rx_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_s != UART_IDLE) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end

      START: begin
        if (cnt_q == '0) begin
          if (rx_s == UART_IDLE) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
            cnt_d   = CNT_FULL;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          cnt_d   = CNT_FULL;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      // Leaving at the stop-bit midpoint leaves half a bit to catch a back-to-back start edge
      STOP: begin
        if (cnt_q == '0) begin
          if (rx_s == UART_IDLE) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      BREAK: begin
        if (rx_s == UART_IDLE) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.data_out  = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule
